// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//
// Program counter and fetch sequencer for a synchronous instruction ROM with a
// one-cycle registered read. The sequencer issues a PC to the ROM and tags it as
// in flight. It presents the returning word to decode together with its PC.
// Words fetched down the wrong path after a branch are squashed. Fetch stops
// when the end-of-program marker arrives or when an address fault is seen.
//
// Optional build macro: FETCH_PERF_CNT_EN. When it is defined, the block adds
// saturating retired/bubble counters and their output ports.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start                 pulse; begin execution at RESET_VECTOR (IDLE/HALT only)
//   suspend_cpu           global stall; freezes every register
//   branch_valid/target   redirect request and target PC
//   rom_instruction       registered ROM read data
//   rom_end_of_program    ROM flag: current data word is the end marker
//   rom_address_exceeded  ROM range flag
//   rom_address           ROM read address (the registered PC)
//   rom_suspend           ROM hold request; high keeps the ROM output unchanged
//   instr_out/pc/valid    instruction, its PC and its valid flag, to decode
//   busy/halted/fault     state RUN / HALT / FAULT
//   retired_count         (FETCH_PERF_CNT_EN) count of valid instruction cycles
//   bubble_count          (FETCH_PERF_CNT_EN) count of unstalled RUN cycles without a valid instruction
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching; one word in flight
// HALT  | end-of-program marker seen; start restarts
// FAULT | address out of range; only rst exits
module instruction_fetch_sequencer #(
    parameter int                  ADDR_W       = 8,
    parameter int                  INSTR_W      = 21,
    parameter int                  ROM_SIZE     = 256,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
    parameter logic [INSTR_W-1:0]  NOP_WORD     = 21'h0000F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               suspend_cpu,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] rom_instruction,
    input  logic               rom_end_of_program,
    input  logic               rom_address_exceeded,
    output logic [ADDR_W-1:0]  rom_address,
    output logic               rom_suspend,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               busy,
    output logic               halted,
    output logic               fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        retired_count,
    output logic [15:0]        bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // One extra bit so that ROM_SIZE = 2**ADDR_W is representable. With that
    // size no PC can exceed the limit, and the PC wraps 255 -> 0 cleanly.
    localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_SIZE);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [ADDR_W-1:0]   pc_d, pc_d_next;
    logic                inflight_v, inflight_v_next;
    logic                squash, squash_next;

    logic                fault_raw;
    logic                eop_raw;
    logic                present;
    logic                start_accept;

    // Fault and end-of-program conditions are evaluated without regard to
    // suspend_cpu. That way the word shown on instr_out stays the same while
    // stalled, and it reappears unchanged on release.
    assign fault_raw    = ({1'b0, pc} >= ROM_LIMIT) || rom_address_exceeded;
    assign eop_raw      = inflight_v && !squash && rom_end_of_program;
    assign start_accept = start && !suspend_cpu && (state == S_IDLE || state == S_HALT);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_VECTOR;
            pc_d       <= '0;
            inflight_v <= 1'b0;
            squash     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pc_d       <= pc_d_next;
            inflight_v <= inflight_v_next;
            squash     <= squash_next;
        end
    end

    // Next-state logic; suspend_cpu holds everything
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pc_d_next       = pc_d;
        inflight_v_next = inflight_v;
        squash_next     = squash;
        if (!suspend_cpu) begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_next      = S_RUN;
                        pc_next         = RESET_VECTOR;
                        inflight_v_next = 1'b0;
                        squash_next     = 1'b0;
                    end
                end
                S_RUN: begin
                    if (fault_raw) begin
                        state_next = S_FAULT;
                    end else if (eop_raw) begin
                        state_next = S_HALT;
                    end else begin
                        pc_d_next       = pc;
                        inflight_v_next = 1'b1;
                        // The word issued alongside a branch is wrong-path.
                        squash_next     = branch_valid;
                        pc_next         = branch_valid ? branch_target : pc + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rom_suspend = 1'b1;
        busy        = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        present     = 1'b0;
        case (state)
            S_RUN: begin
                busy        = 1'b1;
                rom_suspend = suspend_cpu;
                present     = inflight_v && !squash && !fault_raw && !eop_raw;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
        rom_address = pc;
        instr_pc    = pc_d;
        instr_valid = present && !suspend_cpu;
        instr_out   = present ? rom_instruction : NOP_WORD;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
            bubble_count  <= '0;
        end else if (start_accept) begin
            retired_count <= '0;
            bubble_count  <= '0;
        end else begin
            if (instr_valid && retired_count != 16'hFFFF)
                retired_count <= retired_count + 16'd1;
            if (state == S_RUN && !suspend_cpu && !instr_valid && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;

    localparam logic [20:0] NOP  = 21'h0000F;
    localparam logic [20:0] ONES = 21'h1FFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT a: default configuration
    logic        start_a = 0, suspend_a = 0, branch_a = 0, exc_a = 0;
    logic [7:0]  target_a = '0;
    logic [20:0] rom_q_a = '0;
    logic        eop_a;
    logic [7:0]  rom_address_a, instr_pc_a;
    logic        rom_suspend_a, instr_valid_a, busy_a, halted_a, fault_a;
    logic [20:0] instr_out_a;

    // DUT b: ROM_SIZE = 16 for the range fault
    logic        start_b = 0, suspend_b = 0, branch_b = 0, exc_b = 0;
    logic [7:0]  target_b = '0;
    logic [20:0] rom_q_b = '0;
    logic        eop_b;
    logic [7:0]  rom_address_b, instr_pc_b;
    logic        rom_suspend_b, instr_valid_b, busy_b, halted_b, fault_b;
    logic [20:0] instr_out_b;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] retired_a, bubble_a, retired_b, bubble_b;
`endif

    logic [20:0] mem [0:255];
    logic [20:0] seq_words [0:3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural ROMs: one-cycle registered read, held while suspended
    always @(posedge clk) if (!rom_suspend_a) rom_q_a <= mem[rom_address_a];
    always @(posedge clk) if (!rom_suspend_b) rom_q_b <= mem[rom_address_b];
    assign eop_a = (rom_q_a == ONES);
    assign eop_b = (rom_q_b == ONES);

    instruction_fetch_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .suspend_cpu(suspend_a),
        .branch_valid(branch_a), .branch_target(target_a),
        .rom_instruction(rom_q_a), .rom_end_of_program(eop_a),
        .rom_address_exceeded(exc_a), .rom_address(rom_address_a),
        .rom_suspend(rom_suspend_a), .instr_out(instr_out_a), .instr_pc(instr_pc_a),
        .instr_valid(instr_valid_a), .busy(busy_a), .halted(halted_a), .fault(fault_a)
`ifdef FETCH_PERF_CNT_EN
        , .retired_count(retired_a), .bubble_count(bubble_a)
`endif
    );

    instruction_fetch_sequencer #(.ROM_SIZE(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .suspend_cpu(suspend_b),
        .branch_valid(branch_b), .branch_target(target_b),
        .rom_instruction(rom_q_b), .rom_end_of_program(eop_b),
        .rom_address_exceeded(exc_b), .rom_address(rom_address_b),
        .rom_suspend(rom_suspend_b), .instr_out(instr_out_b), .instr_pc(instr_pc_b),
        .instr_valid(instr_valid_b), .busy(busy_b), .halted(halted_b), .fault(fault_b)
`ifdef FETCH_PERF_CNT_EN
        , .retired_count(retired_b), .bubble_count(bubble_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) mem[i] = {13'h0155, 8'(i)};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_a = 0; suspend_a = 0; branch_a = 0; exc_a = 0; target_a = '0;
        start_b = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rom_address_a !== 8'h00) begin failures++; $display("FAIL reset_rom_address: got %h want 00", rom_address_a); end
        checks++; if (rom_suspend_a !== 1'b1) begin failures++; $display("FAIL reset_rom_suspend: got %b want 1", rom_suspend_a); end
        checks++; if (instr_out_a !== NOP) begin failures++; $display("FAIL reset_instr_out: got %h want %h", instr_out_a, NOP); end
        checks++; if (instr_pc_a !== 8'h00) begin failures++; $display("FAIL reset_instr_pc: got %h want 00", instr_pc_a); end
        checks++; if ({instr_valid_a, busy_a, halted_a, fault_a} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {instr_valid_a, busy_a, halted_a, fault_a}); end
    endtask

    task automatic test_straight_line();
        load_default();
        seq_words[0] = 21'h12345; seq_words[1] = 21'h0ABCD;
        seq_words[2] = 21'h1F0F0; seq_words[3] = 21'h00001;
        for (int i = 0; i < 4; i++) mem[i] = seq_words[i];
        mem[4] = ONES;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            step();
            start_a = (c == 0);
            #2;
            if (c >= 2 && c <= 5) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'(c - 2) || instr_out_a !== seq_words[c - 2]) begin
                    failures++; $display("FAIL straight_word c=%0d: got v=%b pc=%h w=%h want v=1 pc=%h w=%h", c, instr_valid_a, instr_pc_a, instr_out_a, 8'(c - 2), seq_words[c - 2]);
                end
            end
            if (c == 6) begin
                checks++; if (instr_valid_a !== 1'b0 || instr_out_a !== NOP) begin
                    failures++; $display("FAIL straight_marker: got v=%b w=%h want v=0 w=%h", instr_valid_a, instr_out_a, NOP);
                end
            end
            if (c == 7) begin
                checks++; if ({halted_a, busy_a, rom_suspend_a, instr_valid_a} !== 4'b1010) begin
                    failures++; $display("FAIL straight_halt: got h/b/s/v=%b want 1010", {halted_a, busy_a, rom_suspend_a, instr_valid_a});
                end
            end
        end
        // Restart from HALT
        step(); start_a = 1;
        step(); start_a = 0;
        step(); #2;
        checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'h00 || instr_out_a !== seq_words[0] || busy_a !== 1'b1) begin
            failures++; $display("FAIL halt_restart: got v=%b pc=%h w=%h busy=%b want v=1 pc=00 w=%h busy=1", instr_valid_a, instr_pc_a, instr_out_a, busy_a, seq_words[0]);
        end
    endtask

    task automatic test_branch();
        load_default();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            step();
            start_a  = (c == 0);
            branch_a = (c == 6);
            target_a = 8'h20;
            #2;
            if (c == 6) begin
                checks++; if (rom_address_a !== 8'h05 || instr_pc_a !== 8'h04 || instr_valid_a !== 1'b1) begin
                    failures++; $display("FAIL branch_issue: got addr=%h pc=%h v=%b want addr=05 pc=04 v=1", rom_address_a, instr_pc_a, instr_valid_a);
                end
            end
            if (c == 7) begin
                checks++; if (instr_valid_a !== 1'b0 || instr_out_a !== NOP) begin
                    failures++; $display("FAIL branch_bubble: got v=%b w=%h want v=0 w=%h", instr_valid_a, instr_out_a, NOP);
                end
            end
            if (c == 8) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'h20 || instr_out_a !== mem[8'h20]) begin
                    failures++; $display("FAIL branch_target: got v=%b pc=%h w=%h want v=1 pc=20 w=%h", instr_valid_a, instr_pc_a, instr_out_a, mem[8'h20]);
                end
            end
            if (c == 9) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'h21) begin
                    failures++; $display("FAIL branch_follow: got v=%b pc=%h want v=1 pc=21", instr_valid_a, instr_pc_a);
                end
`ifdef FETCH_PERF_CNT_EN
                checks++; if (retired_a !== 16'd6) begin failures++; $display("FAIL perf_retired: got %0d want 6", retired_a); end
                checks++; if (bubble_a !== 16'd2) begin failures++; $display("FAIL perf_bubble: got %0d want 2", bubble_a); end
`endif
            end
        end
    endtask

    task automatic test_wrap();
        load_default();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            step();
            start_a  = (c == 0);
            branch_a = (c == 2);
            target_a = 8'hFE;
            #2;
            if (c == 5) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'hFF) begin
                    failures++; $display("FAIL wrap_ff: got v=%b pc=%h want v=1 pc=ff", instr_valid_a, instr_pc_a);
                end
            end
            if (c == 6) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'h00 || instr_out_a !== mem[0] || fault_a !== 1'b0) begin
                    failures++; $display("FAIL wrap_00: got v=%b pc=%h w=%h fault=%b want v=1 pc=00 w=%h fault=0", instr_valid_a, instr_pc_a, instr_out_a, fault_a, mem[0]);
                end
            end
        end
    endtask

    task automatic test_suspend();
        int seen_pc2;
        load_default();
        do_reset();
        seen_pc2 = 0;
        for (int c = 0; c <= 10; c++) begin
            step();
            start_a   = (c == 0);
            suspend_a = (c >= 4 && c <= 6);
            branch_a  = (c == 5);
            target_a  = 8'h40;
            #2;
            if (instr_valid_a === 1'b1 && instr_pc_a === 8'h02) seen_pc2++;
            if (c >= 4 && c <= 6) begin
                checks++; if (instr_valid_a !== 1'b0 || rom_address_a !== 8'h03 || rom_suspend_a !== 1'b1 || instr_pc_a !== 8'h02 || instr_out_a !== mem[2]) begin
                    failures++; $display("FAIL suspend_hold c=%0d: got v=%b addr=%h s=%b pc=%h w=%h want v=0 addr=03 s=1 pc=02 w=%h", c, instr_valid_a, rom_address_a, rom_suspend_a, instr_pc_a, instr_out_a, mem[2]);
                end
            end
            if (c >= 7 && c <= 9) begin
                checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'(c - 5)) begin
                    failures++; $display("FAIL suspend_release c=%0d: got v=%b pc=%h want v=1 pc=%h", c, instr_valid_a, instr_pc_a, 8'(c - 5));
                end
            end
        end
        checks++; if (seen_pc2 != 1) begin failures++; $display("FAIL suspend_pc2_once: got %0d want 1", seen_pc2); end
    endtask

    task automatic test_fault_range();
        int fault_cycle;
        load_default();
        do_reset();
        fault_cycle = -1;
        for (int c = 0; c < 40 && fault_cycle < 0; c++) begin
            step();
            start_b = (c == 0);
            #2;
            if (c == 16) begin
                checks++; if (instr_valid_b !== 1'b1 || instr_pc_b !== 8'h0E) begin
                    failures++; $display("FAIL range_pre: got v=%b pc=%h want v=1 pc=0e", instr_valid_b, instr_pc_b);
                end
            end
            if (fault_b === 1'b1) fault_cycle = c;
        end
        checks++; if (fault_cycle != 18) begin failures++; $display("FAIL range_fault_cycle: got %0d want 18", fault_cycle); end
        checks++; if (instr_valid_b !== 1'b0 || busy_b !== 1'b0 || rom_suspend_b !== 1'b1) begin
            failures++; $display("FAIL range_fault_outputs: got v=%b busy=%b s=%b want 0 0 1", instr_valid_b, busy_b, rom_suspend_b);
        end
        step(); start_b = 1;
        step(); start_b = 0;
        step(); #2;
        checks++; if (fault_b !== 1'b1 || instr_valid_b !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL range_start_ignored: got fault=%b v=%b busy=%b want 1 0 0", fault_b, instr_valid_b, busy_b);
        end
        rst = 1'b1;
        #1;
        checks++; if (fault_b !== 1'b0) begin failures++; $display("FAIL range_rst_clears: got %b want 0", fault_b); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_addr_exceeded();
        load_default();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            step();
            start_a = (c == 0 || c == 6);
            exc_a   = (c == 4);
            #2;
            if (c == 4) begin
                checks++; if (instr_valid_a !== 1'b0 || instr_out_a !== NOP) begin
                    failures++; $display("FAIL exceeded_drop: got v=%b w=%h want v=0 w=%h", instr_valid_a, instr_out_a, NOP);
                end
            end
            if (c == 5 || c == 7) begin
                checks++; if (fault_a !== 1'b1 || instr_valid_a !== 1'b0 || busy_a !== 1'b0) begin
                    failures++; $display("FAIL exceeded_fault c=%0d: got fault=%b v=%b busy=%b want 1 0 0", c, fault_a, instr_valid_a, busy_a);
                end
            end
        end
        exc_a = 0;
    endtask

    task automatic test_reset_midrun();
        bit reached;
        load_default();
        do_reset();
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            step();
            start_a = (c == 0);
            #2;
            if (rom_address_a === 8'h09) reached = 1;
        end
        checks++; if (!reached) begin failures++; $display("FAIL midrun_reach_pc9: got timeout want pc 09"); end
        rst = 1'b1;
        #1;
        checks++; if (rom_address_a !== 8'h00 || rom_suspend_a !== 1'b1 || instr_out_a !== NOP || instr_pc_a !== 8'h00 || instr_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++; $display("FAIL midrun_async_reset: got addr=%h s=%b w=%h pc=%h v=%b busy=%b want 00 1 %h 00 0 0", rom_address_a, rom_suspend_a, instr_out_a, instr_pc_a, instr_valid_a, busy_a, NOP);
        end
        step();
        rst = 1'b0;
        step(); start_a = 1;
        step(); start_a = 0; #2;
        checks++; if (rom_address_a !== 8'h00 || busy_a !== 1'b1) begin
            failures++; $display("FAIL midrun_restart_addr: got addr=%h busy=%b want 00 1", rom_address_a, busy_a);
        end
        step(); #2;
        checks++; if (instr_valid_a !== 1'b1 || instr_pc_a !== 8'h00 || instr_out_a !== mem[0]) begin
            failures++; $display("FAIL midrun_restart_word: got v=%b pc=%h w=%h want v=1 pc=00 w=%h", instr_valid_a, instr_pc_a, instr_out_a, mem[0]);
        end
    endtask

    initial begin
        load_default();
        test_reset();
        test_straight_line();
        test_branch();
        test_wrap();
        test_suspend();
        test_fault_range();
        test_addr_exceeded();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
